// File: rtl/keystone.sv
// Keystone correction mask on a 2-pixel-per-beat AXI4-Stream video path with a 1-deep output slice.
// Define KEYSTONE_PERSPECTIVE_EN to enable the projective w term (H31/H32); otherwise affine only.
module keystone #(
    parameter int FRAME_W = 1920,
    parameter int FRAME_H = 1080
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        aclken,
    input  logic [63:0] s_axis_video_tdata_in,
    input  logic        s_axis_video_tvalid_in,
    output logic        s_axis_video_tready_out,
    input  logic        s_axis_video_tuser_in,
    input  logic        s_axis_video_tlast_in,
    output logic [63:0] s_axis_video_tdata_out,
    output logic        s_axis_video_tvalid_out,
    input  logic        s_axis_video_tready_in,
    output logic        s_axis_video_tuser_out,
    output logic        s_axis_video_tlast_out,
    input  logic        ENABLE_KEYSTONE,
    input  logic        SW_RESET,
    input  logic [31:0] H11,
    input  logic [31:0] H12,
    input  logic [31:0] H13,
    input  logic [31:0] H21,
    input  logic [31:0] H22,
    input  logic [31:0] H23,
    input  logic [31:0] H31,
    input  logic [31:0] H32
);

    localparam logic signed [47:0] ONE   = 48'sh0000_0001_0000;
    localparam logic signed [79:0] FW_WD = 80'(FRAME_W);
    localparam logic signed [79:0] FH_WD = 80'(FRAME_H);

    function automatic logic signed [47:0] sx(input logic [31:0] c);
        return {{16{c[31]}}, c};
    endfunction

    // Limits scale with w so the compare stays divide-free.
    function automatic logic in_range(input logic signed [47:0] u, input logic signed [47:0] v,
                                      input logic signed [47:0] w);
        logic signed [79:0] uw, vw, ww;
        uw = {{32{u[47]}}, u};
        vw = {{32{v[47]}}, v};
        ww = {{32{w[47]}}, w};
        return !w[47] && (w != 48'sd0) && !u[47] && !v[47] && (uw < ww * FW_WD) &&
               (vw < ww * FH_WD);
    endfunction

    logic signed [47:0] acc_u, acc_v, row_u, row_v;
    logic               new_row;
    logic signed [47:0] base_u, base_v, base_w;
    logic signed [47:0] l1_u, l1_v, l1_w;
    logic signed [47:0] nxt_u, nxt_v;
    logic               accept, sof, ok0, ok1;
    logic [63:0]        data_nxt;

`ifdef KEYSTONE_PERSPECTIVE_EN
    logic signed [47:0] acc_w, row_w;
    logic signed [47:0] nxt_w;
`else
    logic               unused_persp;
    assign unused_persp = ^{H31, H32};
`endif

    assign s_axis_video_tready_out = aclken & (s_axis_video_tready_in | ~s_axis_video_tvalid_out);
    assign accept = s_axis_video_tvalid_in & s_axis_video_tready_out;
    assign sof    = s_axis_video_tuser_in;

    always_comb begin
        base_u = acc_u;
        base_v = acc_v;
        base_w = ONE;
`ifdef KEYSTONE_PERSPECTIVE_EN
        base_w = acc_w;
`endif
        if (sof) begin
            base_u = sx(H13);
            base_v = sx(H23);
            base_w = ONE;
        end else if (new_row) begin
            base_u = row_u + sx(H12);
            base_v = row_v + sx(H22);
`ifdef KEYSTONE_PERSPECTIVE_EN
            base_w = row_w + sx(H32);
`endif
        end
        l1_u = base_u + sx(H11);
        l1_v = base_v + sx(H21);
        l1_w = base_w;
`ifdef KEYSTONE_PERSPECTIVE_EN
        l1_w  = base_w + sx(H31);
        nxt_w = l1_w + sx(H31);
`endif
        nxt_u = l1_u + sx(H11);
        nxt_v = l1_v + sx(H21);
        ok0 = in_range(base_u, base_v, base_w);
        ok1 = in_range(l1_u, l1_v, l1_w);
        data_nxt = s_axis_video_tdata_in;
        if (ENABLE_KEYSTONE) begin
            if (!ok0) data_nxt[31:0] = 32'h0;
            if (!ok1) data_nxt[63:32] = 32'h0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_axis_video_tvalid_out <= 1'b0;
            s_axis_video_tdata_out  <= 64'h0;
            s_axis_video_tuser_out  <= 1'b0;
            s_axis_video_tlast_out  <= 1'b0;
            acc_u   <= '0;
            acc_v   <= '0;
            row_u   <= '0;
            row_v   <= '0;
            new_row <= 1'b0;
`ifdef KEYSTONE_PERSPECTIVE_EN
            acc_w <= ONE;
            row_w <= ONE;
`endif
        end else if (aclken && SW_RESET) begin
            s_axis_video_tvalid_out <= 1'b0;
            s_axis_video_tdata_out  <= 64'h0;
            s_axis_video_tuser_out  <= 1'b0;
            s_axis_video_tlast_out  <= 1'b0;
            acc_u   <= '0;
            acc_v   <= '0;
            row_u   <= '0;
            row_v   <= '0;
            new_row <= 1'b0;
`ifdef KEYSTONE_PERSPECTIVE_EN
            acc_w <= ONE;
            row_w <= ONE;
`endif
        end else if (aclken) begin
            if (accept) begin
                acc_u <= nxt_u;
                acc_v <= nxt_v;
`ifdef KEYSTONE_PERSPECTIVE_EN
                acc_w <= nxt_w;
`endif
                if (sof || new_row) begin
                    row_u <= base_u;
                    row_v <= base_v;
`ifdef KEYSTONE_PERSPECTIVE_EN
                    row_w <= base_w;
`endif
                end
                new_row <= s_axis_video_tlast_in;
                s_axis_video_tvalid_out <= 1'b1;
                s_axis_video_tdata_out  <= data_nxt;
                s_axis_video_tuser_out  <= s_axis_video_tuser_in;
                s_axis_video_tlast_out  <= s_axis_video_tlast_in;
            end else if (s_axis_video_tready_in) begin
                s_axis_video_tvalid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keystone.sv
// Directed bench for keystone with a 4x2 frame; expected values worked out by hand.
module tb_keystone;

    logic        aclk = 1'b0;
    logic        areset, aclken;
    logic [63:0] tdata_in, tdata_out;
    logic        tvalid_in, tready_out, tuser_in, tlast_in;
    logic        tvalid_out, tready_in, tuser_out, tlast_out;
    logic        enable, sw_reset;
    logic [31:0] h11, h12, h13, h21, h22, h23, h31, h32;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [63:0] D    = 64'hBBBB_BBBB_AAAA_AAAA;
    localparam logic [63:0] D_HI = 64'hBBBB_BBBB_0000_0000;
    localparam logic [63:0] D_LO = 64'h0000_0000_AAAA_AAAA;
    localparam logic [31:0] P1   = 32'h0001_0000;
    localparam logic [31:0] M1   = 32'hFFFF_0000;

    always #5 aclk = ~aclk;

    keystone #(.FRAME_W(4), .FRAME_H(2)) dut (
        .aclk                    (aclk),
        .areset                  (areset),
        .aclken                  (aclken),
        .s_axis_video_tdata_in   (tdata_in),
        .s_axis_video_tvalid_in  (tvalid_in),
        .s_axis_video_tready_out (tready_out),
        .s_axis_video_tuser_in   (tuser_in),
        .s_axis_video_tlast_in   (tlast_in),
        .s_axis_video_tdata_out  (tdata_out),
        .s_axis_video_tvalid_out (tvalid_out),
        .s_axis_video_tready_in  (tready_in),
        .s_axis_video_tuser_out  (tuser_out),
        .s_axis_video_tlast_out  (tlast_out),
        .ENABLE_KEYSTONE         (enable),
        .SW_RESET                (sw_reset),
        .H11                     (h11),
        .H12                     (h12),
        .H13                     (h13),
        .H21                     (h21),
        .H22                     (h22),
        .H23                     (h23),
        .H31                     (h31),
        .H32                     (h32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic u, input logic l);
        tdata_in  = d;
        tuser_in  = u;
        tlast_in  = l;
        tvalid_in = 1'b1;
        step();
    endtask

    initial begin
        areset = 1'b1; aclken = 1'b1; sw_reset = 1'b0; enable = 1'b1;
        tdata_in = '0; tvalid_in = 1'b0; tuser_in = 1'b0; tlast_in = 1'b0; tready_in = 1'b1;
        h11 = 32'd1; h12 = '0; h13 = '0; h21 = '0; h22 = 32'd1; h23 = '0; h31 = '0; h32 = '0;
        step();
        step();
        areset = 1'b0;
        check("rst_valid", 64'(tvalid_out), 64'd0);
        check("rst_data", tdata_out, 64'h0);
        check("rst_user", 64'(tuser_out), 64'd0);
        check("rst_last", 64'(tlast_out), 64'd0);

        // Tiny raw coefficients: every pixel of the first beats is in range.
        check("rdy_idle", 64'(tready_out), 64'd1);
        send({64{1'b1}}, 1'b1, 1'b0);
        check("b1_valid", 64'(tvalid_out), 64'd1);
        check("b1_data", tdata_out, {64{1'b1}});
        check("b1_user", 64'(tuser_out), 64'd1);
        send({64{1'b1}}, 1'b0, 1'b1);
        check("b2_user", 64'(tuser_out), 64'd0);
        check("b2_last", 64'(tlast_out), 64'd1);
        tvalid_in = 1'b0;
        step();
        check("drain_valid", 64'(tvalid_out), 64'd0);

        // Origin shifted by -1.0: lane0 at u=-1 masked, lane1 at u=0 passes.
        h11 = P1; h13 = M1; h22 = '0;
        send(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        check("neg_sof", tdata_out, 64'h1234_5678_0000_0000);
        send(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        check("neg_b2", tdata_out, 64'h1234_5678_9ABC_DEF0);
        send(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        check("neg_b3", tdata_out, 64'h0000_0000_9ABC_DEF0);
        enable = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        check("bypass", tdata_out, 64'h1234_5678_9ABC_DEF0);

        // Backpressure: output holds, no loss or duplication.
        send(64'hA, 1'b1, 1'b0);
        check("bp_a", tdata_out, 64'hA);
        tdata_in = 64'hB; tuser_in = 1'b0; tready_in = 1'b0;
        #1;
        check("bp_rdy_lo", 64'(tready_out), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", {tdata_out[62:0], tvalid_out}, {63'hA, 1'b1});
        end
        tready_in = 1'b1;
        #1;
        check("bp_rdy_hi", 64'(tready_out), 64'd1);
        step();
        check("bp_b", tdata_out, 64'hB);
        tvalid_in = 1'b0;
        step();
        check("bp_empty", 64'(tvalid_out), 64'd0);

        // 4x2 frame, H12=-1.0 so a new row starts at u=-1, v=1.
        enable = 1'b1; h11 = P1; h12 = M1; h13 = '0; h21 = '0; h22 = P1; h23 = '0;
        send(D, 1'b1, 1'b0);
        check("row0_b1", tdata_out, D);
        send(D, 1'b0, 1'b0);
        check("row0_b2", tdata_out, D);
        send(D, 1'b0, 1'b1);
        check("row0_b3", tdata_out, 64'h0);
        send(D, 1'b0, 1'b0);
        check("row1_b1", tdata_out, D_HI);
        send(D, 1'b0, 1'b1);
        check("row1_b2", tdata_out, D);
        h12 = '0;
        send(D, 1'b0, 1'b0);
        check("row2_v", tdata_out, 64'h0);

        // Soft reset mid-row, then continue without SOF from reset accumulators.
        send(D, 1'b1, 1'b0);
        send(D, 1'b0, 1'b0);
        check("pre_swr", tdata_out, D);
        sw_reset = 1'b1;
        send(D, 1'b0, 1'b0);
        sw_reset = 1'b0;
        check("swr_valid", 64'(tvalid_out), 64'd0);
        check("swr_data", tdata_out, 64'h0);
        send(D, 1'b0, 1'b0);
        check("swr_acc0", tdata_out, D);
        send(D, 1'b0, 1'b0);
        check("swr_acc1", tdata_out, D);
        send(D, 1'b0, 1'b0);
        check("swr_acc2", tdata_out, 64'h0);

        // Clock enable low freezes everything.
        send(D, 1'b1, 1'b0);
        aclken = 1'b0;
        tdata_in = 64'h5;
        #1;
        check("cen_rdy", 64'(tready_out), 64'd0);
        step();
        step();
        check("cen_hold", {tdata_out[62:0], tvalid_out}, {D[62:0], 1'b1});
        aclken = 1'b1;
        tuser_in = 1'b0;
        step();
        check("cen_resume", tdata_out, D_LO & 64'h0 | 64'h5);
        tvalid_in = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
